// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the dual-clock FIFO write side.
//   state_t    : write scheduler ownership state (IDLE / OWN)
//   bin2gray   : binary -> Gray conversion
//   gray2bin   : Gray -> binary conversion
//   gray_full  : full test between a write and a read Gray pointer
// The helpers take operands zero-extended to GRAY_MAX_W bits, so they work for
// any pointer width up to GRAY_MAX_W; callers cast the result back down.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int GRAY_MAX_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    // In Gray code that is: top two bits inverted, the rest equal.
    function automatic logic gray_full(input logic [GRAY_MAX_W-1:0] wr_gray,
                                       input logic [GRAY_MAX_W-1:0] rd_gray,
                                       input int                    addr_w);
        logic [GRAY_MAX_W-1:0] mask;
        mask = GRAY_MAX_W'(3) << (addr_w - 1);
        return (wr_gray ^ rd_gray) == mask;
    endfunction

endpackage

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first requester at or after
// last+1 (modulo NREQ), so 'last' always has the lowest priority.
//   req    in  NREQ   request vector
//   last   in  IDX_W  index that gets lowest priority
//   enable in  1      when low, no grant is produced
//   gnt    out NREQ   one-hot grant (zero when nothing granted)
//   idx    out IDX_W  index of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    input  logic             enable,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        if (enable) begin
            // Walk from the farthest candidate towards last+1; the final hit
            // overwrites earlier ones, so the nearest requester wins.
            for (int k = NREQ; k >= 1; k--) begin
                pos = IDX_W'((int'(last) + k) % NREQ);
                if (req[pos]) begin
                    gnt = NREQ'(1) << pos;
                    idx = pos;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// -----------------------------------------------------------------------------
// fifo_wr_sched
// Write-side scheduler of the dual-clock FIFO. Shares the single write port
// among NREQ producers with round-robin and bounded bursts, owns the write
// pointer (binary + Gray) and derives full / almost_full / level against the
// synchronized read pointer.
//   clk              in   write-domain clock
//   rst              in   synchronous reset, active-high
//   req              in   NREQ         producer i has valid data
//   data             in   NREQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
//   gnt              out  NREQ         one-hot; accept on req[i]&gnt[i]
//   rd_ptr_gray_sync in   ADDR_W+1     read pointer (Gray), synchronized to clk
//   wr_en            out  memory write strobe (one cycle after accept)
//   wr_addr          out  ADDR_W       memory write address
//   wr_data          out  DATA_W       memory write data
//   wr_ptr_gray      out  ADDR_W+1     registered Gray write pointer
//   full             out  FIFO full
//   almost_full      out  level >= depth - AF_MARGIN
//   wr_level         out  ADDR_W+1     fill level seen from the write side
// -----------------------------------------------------------------------------
module fifo_wr_sched
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data,
    output logic [NREQ-1:0]        gnt,
    input  logic [ADDR_W:0]        rd_ptr_gray_sync,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [ADDR_W:0]        wr_ptr_gray,
    output logic                   full,
    output logic                   almost_full,
    output logic [ADDR_W:0]        wr_level
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = ADDR_W + 1;
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;
    logic [PTR_W-1:0] wr_ptr_bin, wr_ptr_bin_inc, rd_ptr_bin;

    logic             owner_req, arb_enable, accept;
    logic [IDX_W-1:0] arb_last, arb_idx, sel_idx;
    logic [NREQ-1:0]  arb_gnt;

    // Status: purely from registers and the synchronized read pointer. A stale
    // read pointer only makes the level look higher, never lower.
    always_comb begin
        rd_ptr_bin     = PTR_W'(gray2bin(GRAY_MAX_W'(rd_ptr_gray_sync)));
        wr_ptr_bin_inc = wr_ptr_bin + 1'b1;
        wr_level       = wr_ptr_bin - rd_ptr_bin;
        full           = gray_full(GRAY_MAX_W'(wr_ptr_gray), GRAY_MAX_W'(rd_ptr_gray_sync), ADDR_W);
        almost_full    = wr_level >= PTR_W'(DEPTH - AF_MARGIN);
    end

    // The owner keeps the port while it requests; otherwise arbitrate, and a
    // releasing owner is treated as 'last' so the handover costs no bubble.
    assign owner_req  = (state == OWN) && req[owner];
    assign arb_last   = (state == OWN) ? owner : last;
    assign arb_enable = !rst && !full && !owner_req;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .last   (arb_last),
        .enable (arb_enable),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    always_comb begin
        gnt     = arb_gnt;
        sel_idx = owner_req ? owner : arb_idx;
        if (owner_req && !rst && !full) begin
            gnt = NREQ'(1) << owner;
        end
        accept = |(req & gnt);
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        if (state == OWN && !req[owner]) begin
            last_nxt  = owner;
            state_nxt = IDLE;
        end
        if (accept) begin
            if (owner_req) begin
                burst_nxt = burst_cnt + 1'b1;
                if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end else begin
                owner_nxt = arb_idx;
                burst_nxt = CNT_W'(1);
                if (MAX_BURST == 1) begin
                    last_nxt  = arb_idx;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = OWN;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= IDX_W'(NREQ - 1);
            burst_cnt   <= '0;
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            wr_en     <= accept;
            if (accept) begin
                wr_ptr_bin  <= wr_ptr_bin_inc;
                wr_ptr_gray <= PTR_W'(bin2gray(GRAY_MAX_W'(wr_ptr_bin_inc)));
                wr_addr     <= wr_ptr_bin[ADDR_W-1:0];
                wr_data     <= data[sel_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule
